// File: rtl/proc_pkg.sv
// Shared encodings for the accumulator processor: opcodes, ALU ops, ACC sources.
package proc_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JZ  = 4'd5;
    localparam logic [3:0] OP_STA = 4'd6;
    localparam logic [3:0] OP_LDA = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_IN  = 4'd9;
    localparam logic [3:0] OP_OUT = 4'd10;
    localparam logic [3:0] OP_HLT = 4'd11;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ACC_ALU = 2'b00,
        ACC_RAM = 2'b01,
        ACC_IMM = 2'b10,
        ACC_IN  = 2'b11
    } acc_scr_e;

endpackage

// File: rtl/datapath_acc_alu.sv
// Combinational ALU: ACC op RAM word, result wraps to DW bits, no flags.
module alu
    import proc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_e       op,
    output logic [DW-1:0] y
);

    // Operation select; add/sub simply truncate to DW bits
    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/datapath_acc.sv
// Accumulator-processor datapath: PC, IR, ACC, ROUT, data RAM and ALU,
// driven cycle by cycle by the controller's control word.
module datapath_acc
    import proc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_scr,
    input  logic          pc_ld,
    input  logic          pc_clr,
    input  logic          ir_ld,
    input  logic          ir_clr,
    input  logic [1:0]    acc_scr,
    input  logic          acc_ld,
    input  logic          acc_clr,
    input  logic [1:0]    alu_op,
    input  logic          rout_ld,
    input  logic          rout_clr,
    input  logic          wr_en,
    input  logic [AW+3:0] instr,
    input  logic [DW-1:0] in_data,
    output logic [AW-1:0] pc_addr,
    output logic [3:0]    opcode,
    output logic          acc_eq_zero,
    output logic [DW-1:0] rout,
    output logic [DW-1:0] acc_q
);

    logic [AW-1:0] pc;
    logic [AW+3:0] ir;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_d;
    logic [DW-1:0] ram_rd;
    logic [DW-1:0] alu_y;
    logic [AW-1:0] opnd;

    // Data RAM is deliberately not reset so contents survive a mid-run reset
    logic [DW-1:0] mem [2**AW];

    assign opnd   = ir[AW-1:0];
    assign ram_rd = mem[opnd];

    alu #(.DW(DW)) u_alu (
        .a  (acc),
        .b  (ram_rd),
        .op (alu_op_e'(alu_op)),
        .y  (alu_y)
    );

    // ACC source select
    always_comb begin
        acc_d = alu_y;
        unique case (acc_scr_e'(acc_scr))
            ACC_ALU: acc_d = alu_y;
            ACC_RAM: acc_d = ram_rd;
            ACC_IMM: acc_d = DW'(opnd);
            ACC_IN:  acc_d = in_data;
            default: acc_d = alu_y;
        endcase
    end

    // PC: clear beats load; load takes PC+1 (wrapping) or the IR operand
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pc <= '0;
        else if (pc_clr) pc <= '0;
        else if (pc_ld)  pc <= pc_scr ? opnd : pc + 1'b1;
    end

    // IR: captures the word fetched at the current PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        ir <= '0;
        else if (ir_clr) ir <= '0;
        else if (ir_ld)  ir <= instr;
    end

    // ACC register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (acc_ld)  acc <= acc_d;
    end

    // ROUT: output latch of ACC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          rout <= '0;
        else if (rout_clr) rout <= '0;
        else if (rout_ld)  rout <= acc;
    end

    // RAM write takes pre-edge ACC; reads of the same address see old data until next cycle
    always_ff @(posedge clk) begin
        if (wr_en) mem[opnd] <= acc;
    end

    assign pc_addr     = pc;
    assign opcode      = ir[AW+3:AW];
    assign acc_eq_zero = (acc == '0);
    assign acc_q       = acc;

endmodule

// File: tb/tb_datapath_acc.sv
// Randomized self-checking bench for datapath_acc with a behavioural model.
module tb_datapath_acc;
    import proc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       pc_scr, pc_ld, pc_clr, ir_ld, ir_clr;
    logic [1:0] acc_scr;
    logic       acc_ld, acc_clr;
    logic [1:0] alu_op;
    logic       rout_ld, rout_clr, wr_en;
    logic [7:0] instr;
    logic [7:0] in_data;
    logic [3:0] pc_addr;
    logic [3:0] opcode;
    logic       acc_eq_zero;
    logic [7:0] rout;
    logic [7:0] acc_q;

    int checks = 0;
    int errors = 0;

    // behavioural state
    int m_pc, m_ir, m_acc, m_rout;
    int m_ram [16];
    int ram_init [16];
    int fib [8] = '{0, 1, 1, 2, 3, 5, 8, 13};

    datapath_acc #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .pc_scr(pc_scr), .pc_ld(pc_ld), .pc_clr(pc_clr),
        .ir_ld(ir_ld), .ir_clr(ir_clr),
        .acc_scr(acc_scr), .acc_ld(acc_ld), .acc_clr(acc_clr),
        .alu_op(alu_op), .rout_ld(rout_ld), .rout_clr(rout_clr),
        .wr_en(wr_en), .instr(instr), .in_data(in_data),
        .pc_addr(pc_addr), .opcode(opcode), .acc_eq_zero(acc_eq_zero),
        .rout(rout), .acc_q(acc_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // every negedge the outputs must match the model
    always @(negedge clk) begin
        chk("pc_addr", int'(pc_addr), m_pc);
        chk("opcode", int'(opcode), m_ir / 16);
        chk("acc_q", int'(acc_q), m_acc);
        chk("acc_eq_zero", int'(acc_eq_zero), (m_acc == 0) ? 1 : 0);
        chk("rout", int'(rout), m_rout);
    end

    task automatic idle();
        pc_scr = 0; pc_ld = 0; pc_clr = 0; ir_ld = 0; ir_clr = 0;
        acc_scr = 2'b00; acc_ld = 0; acc_clr = 0; alu_op = 2'b00;
        rout_ld = 0; rout_clr = 0; wr_en = 0;
        instr = 8'h00; in_data = 8'h00;
    endtask

    task automatic model_clear();
        m_pc = 0; m_ir = 0; m_acc = 0; m_rout = 0;
    endtask

    // advance one clock: model computes next state from the current control word
    task automatic step();
        int o, b, src, n_pc, n_ir, n_acc, n_rout;
        o = m_ir % 16;
        b = m_ram[o];
        case (alu_op)
            2'd0: src = (m_acc + b) % 256;
            2'd1: src = (m_acc - b + 256) % 256;
            2'd2: src = m_acc & b;
            default: src = m_acc ^ b;
        endcase
        if (acc_scr == 2'd1) src = b;
        if (acc_scr == 2'd2) src = o;
        if (acc_scr == 2'd3) src = int'(in_data);
        n_pc   = pc_clr ? 0 : (pc_ld ? (pc_scr ? o : (m_pc + 1) % 16) : m_pc);
        n_ir   = ir_clr ? 0 : (ir_ld ? int'(instr) : m_ir);
        n_acc  = acc_clr ? 0 : (acc_ld ? src : m_acc);
        n_rout = rout_clr ? 0 : (rout_ld ? m_acc : m_rout);
        @(posedge clk);
        if (wr_en) m_ram[o] = m_acc;
        m_pc = n_pc; m_ir = n_ir; m_acc = n_acc; m_rout = n_rout;
        #1;
    endtask

    // fetch the instruction then execute it, as the controller would
    task automatic run(input logic [3:0] op, input logic [3:0] opd, input logic [7:0] din);
        idle();
        ir_ld = 1; pc_ld = 1; instr = {op, opd};
        step();
        idle();
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR: begin acc_ld = 1; acc_scr = 2'b00; alu_op = op[1:0]; end
            OP_JMP: begin pc_ld = 1; pc_scr = 1; end
            OP_JZ:  if (m_acc == 0) begin pc_ld = 1; pc_scr = 1; end
            OP_STA: wr_en = 1;
            OP_LDA: begin acc_ld = 1; acc_scr = 2'b01; end
            OP_LDI: begin acc_ld = 1; acc_scr = 2'b10; end
            OP_IN:  begin acc_ld = 1; acc_scr = 2'b11; in_data = din; end
            OP_OUT: rout_ld = 1;
            default: ;
        endcase
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 0;
        model_clear();
        for (int i = 0; i < 16; i++) begin
            ram_init[i] = int'($urandom_range(255));
            m_ram[i] = 0;
        end
        ram_init[2] = 8'h77;
        ram_init[3] = 8'h12;
        #1;
        chk("reset_acc_eq_zero", int'(acc_eq_zero), 1);
        #11 rst = 1;

        // fill RAM with known values through in_data
        for (int a = 0; a < 16; a++) begin
            idle(); ir_ld = 1; instr = {OP_STA, 4'(a)}; acc_ld = 1; acc_scr = 2'b11;
            in_data = 8'(ram_init[a]);
            step();
            idle(); wr_en = 1;
            step();
        end
        chk("init_ram3", m_ram[3], 8'h12);

        // 1: mid-run reset
        run(OP_IN, 4'd0, 8'h37);
        run(OP_JMP, 4'd5, 8'h00);
        chk("pre_reset_acc", int'(acc_q), 8'h37);
        chk("pre_reset_pc", int'(pc_addr), 5);
        rst = 0;
        model_clear();
        #1;
        chk("rst_pc", int'(pc_addr), 0);
        chk("rst_opcode", int'(opcode), 0);
        chk("rst_acc", int'(acc_q), 0);
        chk("rst_rout", int'(rout), 0);
        chk("rst_zero", int'(acc_eq_zero), 1);
        idle(); acc_ld = 1; pc_ld = 1; ir_ld = 1; instr = 8'hFF;
        @(negedge clk);
        rst = 1;
        run(OP_LDA, 4'd3, 8'h00);
        chk("ram3_kept", int'(acc_q), 8'h12);

        // 2: immediate load, store, read-during-write
        idle(); ir_ld = 1; instr = 8'h85; pc_ld = 1;
        step();
        idle(); acc_ld = 1; acc_scr = 2'b10;
        step();
        chk("ldi5", int'(acc_q), 8'h05);
        idle(); ir_ld = 1; instr = {OP_STA, 4'd2};
        step();
        idle(); wr_en = 1; acc_ld = 1; acc_scr = 2'b01;
        step();
        chk("rdw_old", int'(acc_q), 8'h77);
        idle(); acc_ld = 1; acc_scr = 2'b01;
        step();
        chk("rdw_new", int'(acc_q), 8'h05);

        // 3: ALU ops with ACC=F0, RAM[1]=20
        run(OP_IN, 4'd0, 8'h20); run(OP_STA, 4'd1, 8'h00);
        run(OP_IN, 4'd0, 8'hF0); run(OP_ADD, 4'd1, 8'h00);
        chk("alu_add", int'(acc_q), 8'h10);
        run(OP_IN, 4'd0, 8'hF0); run(OP_SUB, 4'd1, 8'h00);
        chk("alu_sub", int'(acc_q), 8'hD0);
        run(OP_IN, 4'd0, 8'hF0); run(OP_AND, 4'd1, 8'h00);
        chk("alu_and", int'(acc_q), 8'h20);
        run(OP_IN, 4'd0, 8'hF0); run(OP_XOR, 4'd1, 8'h00);
        chk("alu_xor", int'(acc_q), 8'hD0);

        // 4: jump, wrap, clear priority
        run(OP_JMP, 4'd15, 8'h00);
        chk("jmp15", int'(pc_addr), 15);
        idle(); pc_ld = 1;
        step();
        chk("pc_wrap", int'(pc_addr), 0);
        run(OP_JMP, 4'd9, 8'h00);
        chk("jmp9", int'(pc_addr), 9);
        idle(); pc_clr = 1; pc_ld = 1;
        step();
        chk("pc_clr_prio", int'(pc_addr), 0);

        // 5: zero flag
        run(OP_LDI, 4'd1, 8'h00); run(OP_STA, 4'd4, 8'h00);
        run(OP_SUB, 4'd4, 8'h00);
        chk("zero_set", int'(acc_eq_zero), 1);
        run(OP_IN, 4'd0, 8'h2A);
        chk("zero_clr", int'(acc_eq_zero), 0);
        chk("in_2a", int'(acc_q), 8'h2A);

        // 6: ROUT hold and Fibonacci
        run(OP_LDI, 4'd13, 8'h00); run(OP_OUT, 4'd0, 8'h00);
        chk("rout_0d", int'(rout), 8'h0D);
        run(OP_IN, 4'd0, 8'h99); run(OP_JMP, 4'd3, 8'h00);
        chk("rout_hold", int'(rout), 8'h0D);
        run(OP_LDI, 4'd0, 8'h00); run(OP_STA, 4'd1, 8'h00);
        run(OP_LDI, 4'd1, 8'h00); run(OP_STA, 4'd2, 8'h00);
        for (int i = 0; i < 8; i++) begin
            run(OP_LDA, 4'd1, 8'h00); run(OP_OUT, 4'd0, 8'h00);
            chk("fib", int'(rout), fib[i]);
            run(OP_ADD, 4'd2, 8'h00); run(OP_STA, 4'd3, 8'h00);
            run(OP_LDA, 4'd2, 8'h00); run(OP_STA, 4'd1, 8'h00);
            run(OP_LDA, 4'd3, 8'h00); run(OP_STA, 4'd2, 8'h00);
        end

        // random control words against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            pc_scr  = 1'($urandom); pc_ld  = 1'($urandom);
            pc_clr  = ($urandom_range(7) == 0); ir_ld = 1'($urandom);
            ir_clr  = ($urandom_range(7) == 0); acc_scr = 2'($urandom);
            acc_ld  = 1'($urandom); acc_clr = ($urandom_range(7) == 0);
            alu_op  = 2'($urandom); rout_ld = 1'($urandom);
            rout_clr = ($urandom_range(7) == 0); wr_en = 1'($urandom);
            instr   = 8'($urandom); in_data = 8'($urandom);
            step();
        end

        idle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
